clap_sequencer: RTL and testbench
=================================

// Module: clap_sequencer
// PURPOSE
//  Timing/sequencing controller for the clap path: synchronises raw clap_i, turns its rising edges into clap
//  events, rejects echoes with a refractory period and accepts a second clap only inside a timed window.
//  A valid double clap gives a one-cycle clap_set_o pulse and toggles lamp_o.
//  Sits between the microphone comparator input and the lamp/LED driver.
// PARAMETERS
//  REFRACT_CYC  5_000_000   cycles clap events are ignored after each accepted clap (>=1)
//  WINDOW_CYC   50_000_000  cycles after the first refractory period in which a 2nd clap is accepted (>=1)
//  CNT_W        26          timer width; REFRACT_CYC-1 and WINDOW_CYC-1 must fit
// PORTS
//  clk_i         in   1  system clock
//  rst_i         in   1  asynchronous, active-high reset
//  en_i          in   1  sequencer enable; low forces IDLE
//  clap_i        in   1  raw clap level, asynchronous to clk_i
//  clap_state_o  out  2  00 ZERO, 01 ONE, 10 TWO (11 never driven)
//  clap_set_o    out  1  one-cycle pulse on an accepted double clap
//  timeout_o     out  1  one-cycle pulse when the window expires without a 2nd clap
//  lamp_o        out  1  toggles on every clap_set_o pulse
//  dbl_cnt_o     out  8  double-clap count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs, the FSM (IDLE), the timer and the sync flops go to 0 at once; lamp_o=0.
//  Input: 2-FF synchroniser, then a rising-edge detect. evt=1 for one cycle 2 cycles after clk_i first samples
//   clap_i=1. A held-high clap_i gives only one evt.
//  FSM, all outputs registered (clap_state_o in brackets):
//   IDLE  [ZERO]: evt -> LOCK1, timer=0.
//   LOCK1 [ONE] : evt ignored; timer++; timer==REFRACT_CYC-1 -> WAIT2, timer=0.
//   WAIT2 [ONE] : evt -> SET. Otherwise timer++ and timer==WINDOW_CYC-1 -> IDLE with timeout_o=1 for 1 cycle.
//                 If evt and the last window cycle coincide, evt wins (SET, no timeout).
//   SET   [TWO] : lasts 1 cycle; clap_set_o=1; lamp_o toggles; timer=0 -> LOCK2.
//   LOCK2 [TWO] : evt ignored; timer==REFRACT_CYC-1 -> IDLE.
//  en_i=0: next state IDLE from any state; timer=0; evt discarded; no set/timeout pulse; lamp_o holds.
//  A third clap right after a double clap is never accepted. A new sequence needs LOCK2 to finish first.
// CONFIGURATION
//  CLAP_SEQ_COUNT_EN defined: dbl_cnt_o increments on each SET cycle and wraps 255->0; reset value 0.
//  CLAP_SEQ_COUNT_EN undefined: counter not built; dbl_cnt_o tied to 8'h00.
// STRUCTURE
//  Package clap_pkg holds:
//   - clap_state_o encodings CLAP_ZERO=2'b00, CLAP_ONE=2'b01, CLAP_TWO=2'b10;
//   - FSM state encodings IDLE, LOCK1, WAIT2, SET, LOCK2 (3-bit).
//  Sub-module clap_edge_sync (clk_i, rst_i, async_i, evt_o): 2-FF synchroniser plus rising-edge pulse.
//  Top level holds the FSM, the shared CNT_W timer, the lamp flop and the optional counter.
// TESTING
//  Bench parameters: REFRACT_CYC=4, WINDOW_CYC=10.
//  1. Double clap: clap_i 1-cycle pulses 8 cycles apart.
//     -> clap_state_o ZERO->ONE->TWO; one clap_set_o pulse; lamp_o 0->1; back to ZERO after 4 cycles.
//  2. Single clap: no 2nd clap.
//     -> timeout_o pulses exactly 10 cycles after WAIT2 entry; clap_state_o=ZERO; lamp_o unchanged.
//  3. Echo: 2nd pulse 2 cycles after the 1st (inside LOCK1).
//     -> ignored; a 3rd pulse inside the window then gives clap_set_o.
//  4. Coincidence: 2nd evt lands on WAIT2 timer==9.
//     -> clap_set_o=1, timeout_o=0.
//  5. Reset/enable: rst_i asserted mid-WAIT2 -> all outputs 0 immediately;
//     en_i=0 during LOCK1 -> IDLE next cycle, no pulses.
//  6. CLAP_SEQ_COUNT_EN defined: 257 double claps -> dbl_cnt_o==1.
//     Undefined -> dbl_cnt_o stays 0.

Source files
------------

// File: rtl/clap_pkg.sv
// Shared encodings for the clap sequencer: clap-count output codes and FSM states.
package clap_pkg;

   typedef enum logic [1:0] {
      CLAP_ZERO = 2'b00,
      CLAP_ONE  = 2'b01,
      CLAP_TWO  = 2'b10
   } clap_cnt_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOCK1 = 3'd1,
      WAIT2 = 3'd2,
      SET   = 3'd3,
      LOCK2 = 3'd4
   } seq_state_e;

   function automatic clap_cnt_e state_to_claps(input seq_state_e s);
      case (s)
         LOCK1, WAIT2: return CLAP_ONE;
         SET, LOCK2:   return CLAP_TWO;
         default:      return CLAP_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/clap_edge_sync.sv
// Two-flop synchroniser for the raw clap level followed by a registered rising-edge pulse.
module clap_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic evt_o
);

   logic meta_q;
   logic sync_q;
   logic sync_d_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         sync_d_q <= 1'b0;
         evt_o    <= 1'b0;
      end else begin
         meta_q   <= async_i;
         sync_q   <= meta_q;
         sync_d_q <= sync_q;
         evt_o    <= sync_q & ~sync_d_q;
      end
   end

endmodule

// File: rtl/clap_sequencer.sv
// Double-clap sequencer: refractory lockout, timed second-clap window, lamp toggle.
// Optional double-clap counter on dbl_cnt_o is built when CLAP_SEQ_COUNT_EN is defined.
module clap_sequencer
   import clap_pkg::*;
#(
   parameter int REFRACT_CYC = 5_000_000,
   parameter int WINDOW_CYC  = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       clap_i,
   output logic [1:0] clap_state_o,
   output logic       clap_set_o,
   output logic       timeout_o,
   output logic       lamp_o,
   output logic [7:0] dbl_cnt_o
);

   localparam logic [CNT_W-1:0] REFRACT_LAST = CNT_W'(REFRACT_CYC - 1);
   localparam logic [CNT_W-1:0] WINDOW_LAST  = CNT_W'(WINDOW_CYC - 1);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             set_d;
   logic             timeout_d;
   logic             evt;

   clap_edge_sync u_edge_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (clap_i),
      .evt_o   (evt)
   );

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      set_d     = 1'b0;
      timeout_d = 1'b0;
      if (!en_i) begin
         state_d = IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (evt) begin
                  state_d = LOCK1;
                  timer_d = '0;
               end
            end
            LOCK1: begin
               if (timer_q == REFRACT_LAST) begin
                  state_d = WAIT2;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
            WAIT2: begin
               // A clap on the last window cycle still counts as the second clap.
               if (evt) begin
                  state_d = SET;
                  set_d   = 1'b1;
               end else if (timer_q == WINDOW_LAST) begin
                  state_d   = IDLE;
                  timer_d   = '0;
                  timeout_d = 1'b1;
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
            SET: begin
               state_d = LOCK2;
               timer_d = '0;
            end
            LOCK2: begin
               if (timer_q == REFRACT_LAST) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         clap_state_o <= CLAP_ZERO;
         clap_set_o   <= 1'b0;
         timeout_o    <= 1'b0;
         lamp_o       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         clap_state_o <= state_to_claps(state_d);
         clap_set_o   <= set_d;
         timeout_o    <= timeout_d;
         lamp_o       <= lamp_o ^ set_d;
      end
   end

`ifdef CLAP_SEQ_COUNT_EN
   logic [7:0] dbl_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dbl_cnt_q <= 8'h00;
      end else if (set_d) begin
         dbl_cnt_q <= dbl_cnt_q + 8'd1;
      end
   end

   assign dbl_cnt_o = dbl_cnt_q;
`else
   assign dbl_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_clap_sequencer.sv
// Bench for clap_sequencer: timestamp-based reference model compared every cycle, plus directed literal checks.
module tb_clap_sequencer;

   localparam int R = 4;
   localparam int W = 10;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       en_i;
   logic       clap_i;
   logic [1:0] clap_state_o;
   logic       clap_set_o;
   logic       timeout_o;
   logic       lamp_o;
   logic [7:0] dbl_cnt_o;

   clap_sequencer #(
      .REFRACT_CYC (R),
      .WINDOW_CYC  (W),
      .CNT_W       (8)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_i         (en_i),
      .clap_i       (clap_i),
      .clap_state_o (clap_state_o),
      .clap_set_o   (clap_set_o),
      .timeout_o    (timeout_o),
      .lamp_o       (lamp_o),
      .dbl_cnt_o    (dbl_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int k     = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: phase 0 = no clap, 1 = first clap accepted at edge t0, 2 = double clap at edge t1.
   logic [3:0] hist;
   int         phase, t0, t1, m_cnt;
   logic       m_set, m_to, m_lamp, ev;
   logic [1:0] m_state;

   always @(posedge clk_i) begin
      cyc++;
      if (rst_i) begin
         hist = 4'b0; phase = 0; t0 = 0; t1 = 0; m_cnt = 0;
         m_set = 1'b0; m_to = 1'b0; m_lamp = 1'b0;
      end else begin
         ev    = hist[2] & ~hist[3];
         hist  = {hist[2:0], clap_i};
         m_set = 1'b0;
         m_to  = 1'b0;
         if (!en_i) begin
            phase = 0;
         end else if (phase == 0) begin
            if (ev) begin phase = 1; t0 = cyc; end
         end else if (phase == 1) begin
            if (ev && cyc > t0 + R) begin
               phase = 2; t1 = cyc; m_set = 1'b1; m_lamp = ~m_lamp;
               m_cnt = (m_cnt + 1) % 256;
            end else if (cyc == t0 + R + W) begin
               phase = 0; m_to = 1'b1;
            end
         end else if (cyc == t1 + R + 1) begin
            phase = 0;
         end
      end
      m_state = (phase == 0) ? 2'b00 : (phase == 1) ? 2'b01 : 2'b10;
      #1;
      chk("model_state",   {6'b0, clap_state_o}, {6'b0, m_state});
      chk("model_set",     {7'b0, clap_set_o},   {7'b0, m_set});
      chk("model_timeout", {7'b0, timeout_o},    {7'b0, m_to});
      chk("model_lamp",    {7'b0, lamp_o},       {7'b0, m_lamp});
`ifdef CLAP_SEQ_COUNT_EN
      chk("model_cnt", dbl_cnt_o, 8'(m_cnt));
`else
      chk("model_cnt", dbl_cnt_o, 8'h00);
`endif
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) step(1);
   endtask

   task automatic start_seq();
      k = cyc + 1;
   endtask

   task automatic pulse_at(input int off);
      wait_to(k + off - 1);
      clap_i = 1'b1;
      step(1);
      clap_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; en_i = 1'b1; clap_i = 1'b0;
      step(3);
      chk("reset_state", {6'b0, clap_state_o}, 8'd0);
      chk("reset_lamp",  {7'b0, lamp_o},       8'd0);
      chk("reset_cnt",   dbl_cnt_o,            8'd0);
      rst_i = 1'b0;
      step(2);

      // Double clap, 8 cycles apart
      start_seq(); pulse_at(0); pulse_at(8);
      wait_to(k + 3);  chk("dbl_state_one",  {6'b0, clap_state_o}, 8'd1);
      wait_to(k + 10); chk("dbl_no_set_yet", {7'b0, clap_set_o},   8'd0);
      wait_to(k + 11); chk("dbl_set",        {7'b0, clap_set_o},   8'd1);
                       chk("dbl_state_two",  {6'b0, clap_state_o}, 8'd2);
                       chk("dbl_lamp_on",    {7'b0, lamp_o},       8'd1);
`ifdef CLAP_SEQ_COUNT_EN
                       chk("dbl_cnt_one",    dbl_cnt_o,            8'd1);
`else
                       chk("dbl_cnt_zero",   dbl_cnt_o,            8'd0);
`endif
      wait_to(k + 15); chk("dbl_lock2_two",  {6'b0, clap_state_o}, 8'd2);
      wait_to(k + 16); chk("dbl_back_zero",  {6'b0, clap_state_o}, 8'd0);
      wait_to(k + 20);

      // Single clap -> timeout 10 cycles after window entry (edge k+7)
      start_seq(); pulse_at(0);
      wait_to(k + 16); chk("single_no_to_yet", {7'b0, timeout_o},    8'd0);
                       chk("single_still_one", {6'b0, clap_state_o}, 8'd1);
      wait_to(k + 17); chk("single_timeout",   {7'b0, timeout_o},    8'd1);
                       chk("single_zero",      {6'b0, clap_state_o}, 8'd0);
                       chk("single_lamp_hold", {7'b0, lamp_o},       8'd1);
      wait_to(k + 22);

      // Echo inside refractory period, then third clap inside the window
      start_seq(); pulse_at(0); pulse_at(2); pulse_at(10);
      wait_to(k + 12); chk("echo_no_set",  {7'b0, clap_set_o}, 8'd0);
      wait_to(k + 13); chk("echo_set",     {7'b0, clap_set_o}, 8'd1);
                       chk("echo_lamp",    {7'b0, lamp_o},     8'd0);
      wait_to(k + 22);

      // Second clap on the last window cycle
      start_seq(); pulse_at(0); pulse_at(14);
      wait_to(k + 17); chk("coinc_set",     {7'b0, clap_set_o}, 8'd1);
                       chk("coinc_no_to",   {7'b0, timeout_o},  8'd0);
                       chk("coinc_lamp",    {7'b0, lamp_o},     8'd1);
      wait_to(k + 26);

      // Enable dropped during LOCK1
      start_seq(); pulse_at(0);
      wait_to(k + 4); chk("en_lock1", {6'b0, clap_state_o}, 8'd1);
      en_i = 1'b0;
      step(1);        chk("en_idle",  {6'b0, clap_state_o}, 8'd0);
      en_i = 1'b1;
      wait_to(k + 25); chk("en_lamp_hold", {7'b0, lamp_o}, 8'd1);

      // Asynchronous reset in the middle of WAIT2
      start_seq(); pulse_at(0);
      wait_to(k + 9); chk("rst_pre_wait2", {6'b0, clap_state_o}, 8'd1);
      #1 rst_i = 1'b1;
      #1;
      chk("rst_async_state",   {6'b0, clap_state_o}, 8'd0);
      chk("rst_async_lamp",    {7'b0, lamp_o},       8'd0);
      chk("rst_async_set",     {7'b0, clap_set_o},   8'd0);
      chk("rst_async_timeout", {7'b0, timeout_o},    8'd0);
      chk("rst_async_cnt",     dbl_cnt_o,            8'd0);
      step(2);
      rst_i = 1'b0;
      step(2);

      // 257 double claps: counter wraps to 1, lamp ends on
      for (int i = 0; i < 257; i++) begin
         start_seq(); pulse_at(0); pulse_at(8);
         wait_to(k + 19);
      end
      chk("wrap_lamp", {7'b0, lamp_o}, 8'd1);
`ifdef CLAP_SEQ_COUNT_EN
      chk("wrap_cnt", dbl_cnt_o, 8'd1);
`else
      chk("wrap_cnt", dbl_cnt_o, 8'd0);
`endif

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
